parser_type_lookup: RTL and testbench

Per-layer rule-match stage of the pipelined parser. Consumes one `layer_info_t` per cycle, extracts `TYPE_NUM` type bytes from the head, matches them against a `RULE_NUM`-entry runtime-writable type-rule table, and emits the winning rule as `lookup_rst_t`. Head and meta pass through alongside it to the downstream extract/shift stage. Fully pipelined with a fixed 2-cycle latency and no backpressure.

---
 rtl/parser_pkg.sv | 54 +++++
 rtl/parser_rule_table.sv | 27 ++
 rtl/parser_type_lookup.sv | 143 ++++++++++++++
 tb/tb_parser_type_lookup.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/parser_pkg.sv
// Shared parser types and widths: layer descriptor, type-rule entry and lookup result.
package parser_pkg;

  localparam int HEAD_WIDTH      = 512;
  localparam int TAG_WIDTH       = 8;
  localparam int META_WIDTH      = 128;
  localparam int TYPE_NUM        = 2;
  localparam int KEY_NUM         = 8;
  localparam int META_CANDI_NUM  = 4;
  localparam int RULE_NUM        = 8;
  localparam int RULE_IDX_WIDTH  = $clog2(RULE_NUM);
  localparam int KEY_IDX_WIDTH   = $clog2(KEY_NUM);
  localparam int CANDI_IDX_WIDTH = $clog2(META_CANDI_NUM);

  typedef struct packed {
    logic [TYPE_NUM-1:0][5:0]           type_offset;
    logic [HEAD_WIDTH+TAG_WIDTH-1:0]    head;
    logic [META_WIDTH+TAG_WIDTH-1:0]    meta;
  } layer_info_t;

  typedef struct packed {
    logic                                    typeRule_valid;
    logic [TYPE_NUM-1:0][7:0]                typeRule_typeData;
    logic [TYPE_NUM-1:0][7:0]                typeRule_typeMask;
    logic [TYPE_NUM-1:0][5:0]                typeRule_typeOffset;
    logic [KEY_NUM-1:0][5:0]                 typeRule_keyOffset;
    logic [KEY_NUM-1:0][CANDI_IDX_WIDTH-1:0] typeRule_keyReplaceOffset;
    logic [5:0]                              typeRule_headShift;
    logic [5:0]                              typeRule_metaShift;
  } type_rule_t;

  typedef struct packed {
    logic [TYPE_NUM-1:0][5:0]                typeOffset;
    logic [KEY_NUM-1:0][5:0]                 keyOffset;
    logic [META_CANDI_NUM-1:0][KEY_IDX_WIDTH:0] replaceOffset;
    logic [5:0]                              headShift;
    logic [5:0]                              metaShift;
  } lookup_rst_t;

  // The subset of a rule that S2 needs, captured in S1 so later writes cannot disturb it.
  typedef struct packed {
    logic [TYPE_NUM-1:0][5:0]                typeOffset;
    logic [KEY_NUM-1:0][5:0]                 keyOffset;
    logic [KEY_NUM-1:0][CANDI_IDX_WIDTH-1:0] keyReplaceOffset;
    logic [5:0]                              headShift;
    logic [5:0]                              metaShift;
  } win_rule_t;

  function automatic logic [7:0] type_byte(input logic [HEAD_WIDTH-1:0] data,
                                           input logic [5:0] off);
    return 8'(data >> (HEAD_WIDTH - 8 - 8 * int'(off)));
  endfunction

endpackage

// File: rtl/parser_rule_table.sv
// Runtime-writable type-rule table; every entry is visible combinationally.
module parser_rule_table
  import parser_pkg::*;
#(
  parameter int RULE_NUM = parser_pkg::RULE_NUM
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_wren,
  input  logic [RULE_IDX_WIDTH-1:0] i_addr,
  input  type_rule_t                i_rule,
  output type_rule_t                o_rules [RULE_NUM]
);

  type_rule_t rules_q [RULE_NUM];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < RULE_NUM; r++) rules_q[r] <= '0;
    end else if (i_wren) begin
      rules_q[i_addr] <= i_rule;
    end
  end

  assign o_rules = rules_q;

endmodule

// File: rtl/parser_type_lookup.sv
// Per-layer rule match: S1 extracts type bytes and compares against all rules,
// S2 picks the lowest-index hit and builds the lookup result.
module parser_type_lookup
  import parser_pkg::*;
#(
  parameter int RULE_NUM = parser_pkg::RULE_NUM
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_info_valid,
  input  layer_info_t                     i_info,
  input  logic                            i_rule_wren,
  input  logic [RULE_IDX_WIDTH-1:0]       i_rule_addr,
  input  type_rule_t                      i_rule,
  output logic                            o_info_valid,
  output logic                            o_hit,
  output logic [RULE_IDX_WIDTH-1:0]       o_hit_idx,
  output lookup_rst_t                     o_lookup_rst,
  output logic [HEAD_WIDTH+TAG_WIDTH-1:0] o_head,
  output logic [META_WIDTH+TAG_WIDTH-1:0] o_meta
);

  type_rule_t rules [RULE_NUM];

  parser_rule_table #(.RULE_NUM(RULE_NUM)) u_rule_table (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_wren  (i_rule_wren),
    .i_addr  (i_rule_addr),
    .i_rule  (i_rule),
    .o_rules (rules)
  );

  // S1: extract + compare
  logic [HEAD_WIDTH-1:0]    data;
  logic [TYPE_NUM-1:0][7:0] type_b;
  logic [RULE_NUM-1:0]      hit_vec_d;
  win_rule_t                win_d;

  assign data = i_info.head[HEAD_WIDTH+TAG_WIDTH-1:TAG_WIDTH];

  always_comb begin
    hit_vec_d = '0;
    win_d     = '0;
    for (int i = 0; i < TYPE_NUM; i++) type_b[i] = type_byte(data, i_info.type_offset[i]);
    for (int r = 0; r < RULE_NUM; r++) begin
      hit_vec_d[r] = rules[r].typeRule_valid;
      for (int i = 0; i < TYPE_NUM; i++) begin
        if (((type_b[i] ^ rules[r].typeRule_typeData[i]) & rules[r].typeRule_typeMask[i]) != 8'd0)
          hit_vec_d[r] = 1'b0;
      end
    end
    for (int r = RULE_NUM - 1; r >= 0; r--) begin
      if (hit_vec_d[r]) begin
        win_d.typeOffset       = rules[r].typeRule_typeOffset;
        win_d.keyOffset        = rules[r].typeRule_keyOffset;
        win_d.keyReplaceOffset = rules[r].typeRule_keyReplaceOffset;
        win_d.headShift        = rules[r].typeRule_headShift;
        win_d.metaShift        = rules[r].typeRule_metaShift;
      end
    end
  end

  logic                            s1_vld_q;
  logic [RULE_NUM-1:0]             s1_hit_vec_q;
  win_rule_t                       s1_win_q;
  logic [HEAD_WIDTH+TAG_WIDTH-1:0] s1_head_q;
  logic [META_WIDTH+TAG_WIDTH-1:0] s1_meta_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) s1_vld_q <= 1'b0;
    else          s1_vld_q <= i_info_valid;
  end

  always_ff @(posedge i_clk) begin
    if (i_info_valid) begin
      s1_hit_vec_q <= hit_vec_d;
      s1_win_q     <= win_d;
      s1_head_q    <= i_info.head;
      s1_meta_q    <= i_info.meta;
    end
  end

  // S2: select + build
  logic                      hit_d;
  logic [RULE_IDX_WIDTH-1:0] hit_idx_d;
  lookup_rst_t               rst_d;

  always_comb begin
    hit_d     = |s1_hit_vec_q;
    hit_idx_d = '0;
    rst_d     = '0;
    for (int r = RULE_NUM - 1; r >= 0; r--)
      if (s1_hit_vec_q[r]) hit_idx_d = RULE_IDX_WIDTH'(r);
    if (hit_d) begin
      rst_d.typeOffset = s1_win_q.typeOffset;
      rst_d.keyOffset  = s1_win_q.keyOffset;
      rst_d.headShift  = s1_win_q.headShift;
      rst_d.metaShift  = s1_win_q.metaShift;
      for (int j = 0; j < META_CANDI_NUM; j++) begin
        for (int k = KEY_NUM - 1; k >= 0; k--) begin
          if (s1_win_q.keyOffset[k][5] && (s1_win_q.keyReplaceOffset[k] == CANDI_IDX_WIDTH'(j)))
            rst_d.replaceOffset[j] = {1'b1, KEY_IDX_WIDTH'(k)};
        end
      end
    end
  end

  logic                            vld_q;
  logic                            hit_q;
  logic [RULE_IDX_WIDTH-1:0]       hit_idx_q;
  lookup_rst_t                     rst_q;
  logic [HEAD_WIDTH+TAG_WIDTH-1:0] head_q;
  logic [META_WIDTH+TAG_WIDTH-1:0] meta_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_q     <= 1'b0;
      hit_q     <= 1'b0;
      hit_idx_q <= '0;
      rst_q     <= '0;
      head_q    <= '0;
      meta_q    <= '0;
    end else begin
      vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        hit_q     <= hit_d;
        hit_idx_q <= hit_idx_d;
        rst_q     <= rst_d;
        head_q    <= s1_head_q;
        meta_q    <= s1_meta_q;
      end
    end
  end

  assign o_info_valid = vld_q;
  assign o_hit        = hit_q;
  assign o_hit_idx    = hit_idx_q;
  assign o_lookup_rst = rst_q;
  assign o_head       = head_q;
  assign o_meta       = meta_q;

endmodule

// File: tb/tb_parser_type_lookup.sv
// Directed bench for parser_type_lookup with a reference lookup model and per-cycle compare.
module tb_parser_type_lookup;
  import parser_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                            rst_n;
  logic                            info_valid;
  layer_info_t                     info;
  logic                            rule_wren;
  logic [RULE_IDX_WIDTH-1:0]       rule_addr;
  type_rule_t                      rule;
  logic                            o_info_valid;
  logic                            o_hit;
  logic [RULE_IDX_WIDTH-1:0]       o_hit_idx;
  lookup_rst_t                     o_lookup_rst;
  logic [HEAD_WIDTH+TAG_WIDTH-1:0] o_head;
  logic [META_WIDTH+TAG_WIDTH-1:0] o_meta;

  parser_type_lookup dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_info_valid (info_valid),
    .i_info       (info),
    .i_rule_wren  (rule_wren),
    .i_rule_addr  (rule_addr),
    .i_rule       (rule),
    .o_info_valid (o_info_valid),
    .o_hit        (o_hit),
    .o_hit_idx    (o_hit_idx),
    .o_lookup_rst (o_lookup_rst),
    .o_head       (o_head),
    .o_meta       (o_meta)
  );

  int tests = 0;
  int fails = 0;
  int out_cnt = 0;

  task automatic chk(input string nm, input logic [639:0] act, input logic [639:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic                            valid;
    logic                            hit;
    logic [RULE_IDX_WIDTH-1:0]       idx;
    lookup_rst_t                     rst;
    logic [HEAD_WIDTH+TAG_WIDTH-1:0] head;
    logic [META_WIDTH+TAG_WIDTH-1:0] meta;
  } exp_t;

  type_rule_t model_rules [RULE_NUM];
  exp_t e1, e2;

  // Reference: first valid rule whose masked type bytes equal the layer's bytes.
  function automatic exp_t predict(input layer_info_t inf);
    exp_t p;
    logic [7:0] bytes [64];
    logic ok;
    type_rule_t w;
    for (int n = 0; n < 64; n++) bytes[n] = inf.head[HEAD_WIDTH+TAG_WIDTH-1-8*n -: 8];
    p = '0;
    p.valid = 1'b1;
    p.head = inf.head;
    p.meta = inf.meta;
    for (int r = 0; r < RULE_NUM; r++) begin
      w = model_rules[r];
      ok = w.typeRule_valid;
      for (int i = 0; i < TYPE_NUM; i++)
        if ((bytes[inf.type_offset[i]] & w.typeRule_typeMask[i]) !=
            (w.typeRule_typeData[i] & w.typeRule_typeMask[i])) ok = 1'b0;
      if (ok) begin
        p.hit = 1'b1;
        p.idx = RULE_IDX_WIDTH'(r);
        p.rst.typeOffset = w.typeRule_typeOffset;
        p.rst.keyOffset  = w.typeRule_keyOffset;
        p.rst.headShift  = w.typeRule_headShift;
        p.rst.metaShift  = w.typeRule_metaShift;
        for (int j = 0; j < META_CANDI_NUM; j++)
          for (int k = 0; k < KEY_NUM; k++)
            if (w.typeRule_keyOffset[k][5] && int'(w.typeRule_keyReplaceOffset[k]) == j) begin
              p.rst.replaceOffset[j] = {1'b1, KEY_IDX_WIDTH'(k)};
              break;
            end
        break;
      end
    end
    return p;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e1 = '0;
      e2 = '0;
      for (int r = 0; r < RULE_NUM; r++) model_rules[r] = '0;
    end else begin
      e2 = e1;
      e1 = info_valid ? predict(info) : '0;
      if (rule_wren) model_rules[rule_addr] = rule;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cyc_valid", 640'(o_info_valid), 640'(e2.valid));
      if (e2.valid) begin
        chk("cyc_hit",  640'(o_hit),        640'(e2.hit));
        chk("cyc_idx",  640'(o_hit_idx),    640'(e2.idx));
        chk("cyc_rst",  640'(o_lookup_rst), 640'(e2.rst));
        chk("cyc_head", 640'(o_head),       640'(e2.head));
        chk("cyc_meta", 640'(o_meta),       640'(e2.meta));
      end
      if (o_info_valid) out_cnt++;
    end
  end

  function automatic type_rule_t mk_rule(input logic [7:0] d0, d1, m0, m1,
                                         input logic [5:0] o0, o1, hs, ms);
    type_rule_t t;
    t = '0;
    t.typeRule_valid = 1'b1;
    t.typeRule_typeData[0] = d0;  t.typeRule_typeData[1] = d1;
    t.typeRule_typeMask[0] = m0;  t.typeRule_typeMask[1] = m1;
    t.typeRule_typeOffset[0] = o0; t.typeRule_typeOffset[1] = o1;
    t.typeRule_headShift = hs;
    t.typeRule_metaShift = ms;
    return t;
  endfunction

  function automatic layer_info_t mk_info(input logic [7:0] seed, input logic [5:0] o0, o1,
                                          input logic [7:0] v0, v1);
    layer_info_t f;
    f = '0;
    for (int n = 0; n < 64; n++) f.head[HEAD_WIDTH+TAG_WIDTH-1-8*n -: 8] = 8'(n * 3) + seed;
    f.head[HEAD_WIDTH+TAG_WIDTH-1-8*int'(o0) -: 8] = v0;
    f.head[HEAD_WIDTH+TAG_WIDTH-1-8*int'(o1) -: 8] = v1;
    f.head[TAG_WIDTH-1:0] = seed;
    f.meta = {{16{seed ^ 8'hA5}}, seed};
    f.type_offset[0] = o0;
    f.type_offset[1] = o1;
    return f;
  endfunction

  task automatic step(input logic v, input layer_info_t inf, input logic w,
                      input logic [RULE_IDX_WIDTH-1:0] a, input type_rule_t r);
    @(negedge clk);
    info_valid = v;
    info       = inf;
    rule_wren  = w;
    rule_addr  = a;
    rule       = r;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, '0);
  endtask

  type_rule_t  r_ipv4, r_p2, r_p5;
  layer_info_t in_ipv4, in_miss, in_pri;
  lookup_rst_t lr;
  int cnt0;

  initial begin
    r_ipv4 = mk_rule(8'h08, 8'h00, 8'hFF, 8'hFF, 6'd12, 6'd13, 6'd7, 6'd0);
    r_ipv4.typeRule_keyOffset[0] = 6'b1_00000;
    r_ipv4.typeRule_keyReplaceOffset[0] = 2'd3;
    r_p2 = mk_rule(8'h11, 8'h22, 8'hFF, 8'hFF, 6'd0, 6'd1, 6'd9, 6'd2);
    r_p2.typeRule_keyOffset[1] = 6'b1_00101; r_p2.typeRule_keyReplaceOffset[1] = 2'd0;
    r_p2.typeRule_keyOffset[2] = 6'b1_00111; r_p2.typeRule_keyReplaceOffset[2] = 2'd0;
    r_p2.typeRule_keyOffset[3] = 6'b0_00001; r_p2.typeRule_keyReplaceOffset[3] = 2'd2;
    r_p5 = mk_rule(8'hAA, 8'hBB, 8'h00, 8'h00, 6'd4, 6'd5, 6'd20, 6'd5);
    in_ipv4 = mk_info(8'h01, 6'd12, 6'd13, 8'h08, 8'h00);
    in_miss = mk_info(8'h02, 6'd12, 6'd13, 8'h86, 8'hDD);
    in_pri  = mk_info(8'h10, 6'd0, 6'd1, 8'h11, 8'h22);

    rst_n = 1'b0;
    info_valid = 1'b0; info = '0; rule_wren = 1'b0; rule_addr = '0; rule = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 640'(o_info_valid), 640'(0));
    chk("rst_hit",   640'(o_hit),        640'(0));
    chk("rst_idx",   640'(o_hit_idx),    640'(0));
    chk("rst_lrst",  640'(o_lookup_rst), 640'(0));
    chk("rst_head",  640'(o_head),       640'(0));
    chk("rst_meta",  640'(o_meta),       640'(0));
    rst_n = 1'b1;
    idle(2);

    // IPv4 ethertype hit
    step(1'b0, '0, 1'b1, 3'd0, r_ipv4);
    step(1'b1, in_ipv4, 1'b0, '0, '0);
    idle(2);
    lr = '0;
    lr.replaceOffset[3] = 4'b1000;
    chk("ipv4_hit",     640'(o_hit),                      640'(1));
    chk("ipv4_idx",     640'(o_hit_idx),                  640'(0));
    chk("ipv4_hshift",  640'(o_lookup_rst.headShift),     640'(7));
    chk("ipv4_replace", 640'(o_lookup_rst.replaceOffset), 640'(lr.replaceOffset));
    chk("ipv4_key0",    640'(o_lookup_rst.keyOffset[0]),  640'(6'b1_00000));

    // Miss with only the IPv4 rule present
    step(1'b1, in_miss, 1'b0, '0, '0);
    idle(2);
    chk("miss_valid", 640'(o_info_valid), 640'(1));
    chk("miss_hit",   640'(o_hit),        640'(0));
    chk("miss_lrst",  640'(o_lookup_rst), 640'(0));
    chk("miss_head",  640'(o_head),       640'(in_miss.head));
    chk("miss_meta",  640'(o_meta),       640'(in_miss.meta));

    // Priority between rules 2 and 5, then with rule 2 deleted
    step(1'b0, '0, 1'b1, 3'd2, r_p2);
    step(1'b0, '0, 1'b1, 3'd5, r_p5);
    step(1'b1, in_pri, 1'b0, '0, '0);
    idle(2);
    lr = '0;
    lr.replaceOffset[0] = 4'b1001;
    chk("pri_idx2",    640'(o_hit_idx),                  640'(2));
    chk("pri_replace", 640'(o_lookup_rst.replaceOffset), 640'(lr.replaceOffset));
    step(1'b0, '0, 1'b1, 3'd2, '0);
    step(1'b1, in_pri, 1'b0, '0, '0);
    idle(2);
    chk("pri_idx5",   640'(o_hit_idx),              640'(5));
    chk("pri_hshift", 640'(o_lookup_rst.headShift), 640'(20));

    // Same-cycle write and lookup sees the old table
    step(1'b0, '0, 1'b1, 3'd5, '0);
    step(1'b0, '0, 1'b1, 3'd0, '0);
    step(1'b1, in_ipv4, 1'b1, 3'd0, r_ipv4);
    step(1'b1, in_ipv4, 1'b0, '0, '0);
    idle(1);
    chk("coll_miss", 640'(o_hit), 640'(0));
    idle(1);
    chk("coll_hit",  640'(o_hit), 640'(1));

    // Back-to-back alternating hit/miss
    idle(3);
    #1 cnt0 = out_cnt;
    for (int n = 0; n < 16; n++)
      step(1'b1, (n % 2 == 0) ? mk_info(8'(n), 6'd12, 6'd13, 8'h08, 8'h00)
                              : mk_info(8'(n), 6'd12, 6'd13, 8'h86, 8'hDD),
           1'b0, '0, '0);
    idle(3);
    #1 chk("b2b_count", 640'(out_cnt - cnt0), 640'(16));

    // Reset with two items in flight
    step(1'b1, mk_info(8'h28, 6'd12, 6'd13, 8'h08, 8'h00), 1'b0, '0, '0);
    step(1'b1, mk_info(8'h29, 6'd12, 6'd13, 8'h08, 8'h00), 1'b0, '0, '0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_valid", 640'(o_info_valid), 640'(0));
    chk("mrst_hit",   640'(o_hit),        640'(0));
    chk("mrst_head",  640'(o_head),       640'(0));
    chk("mrst_lrst",  640'(o_lookup_rst), 640'(0));
    info_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    step(1'b1, in_ipv4, 1'b0, '0, '0);
    idle(2);
    chk("prst_valid", 640'(o_info_valid), 640'(1));
    chk("prst_miss",  640'(o_hit),        640'(0));
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
